// File: rtl/stage_envelope.sv
// rtl/stage_envelope.sv - per-slot four-stage envelope generator with a two-cycle sample pipeline
module stage_envelope #(
    parameter int NUM_VOICE_OPS = 256
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic [7:0]         i_VoiceOperator,
    input  logic signed [15:0] i_Waveform,
    input  logic [31:0]        i_NoteOn,
    input  logic               i_EnvWriteEnable,
    input  logic [2:0]         i_EnvWriteParam,
    input  logic [7:0]         i_EnvWriteAddr,
    input  logic [7:0]         i_EnvWriteData,
    output logic [7:0]         o_VoiceOperator,
    output logic signed [15:0] o_Sample,
    output logic [7:0]         o_EnvelopeLevel,
    output logic               o_Busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4
    } stage_t;

    localparam logic [7:0] LAST_SLOT = 8'(NUM_VOICE_OPS - 1);

    // Per-slot state and host-owned config; config bytes 0-3 are L1-L4, 4-7 are R1-R4
    stage_t          stage_mem [NUM_VOICE_OPS];
    logic [15:0]     level_mem [NUM_VOICE_OPS];
    logic            prev_mem  [NUM_VOICE_OPS];
    logic [7:0][7:0] cfg_mem   [NUM_VOICE_OPS];

    logic            busy;
    logic [7:0]      sweep_addr;

    logic [7:0]         p1_id;
    logic signed [15:0] p1_wave;
    logic               p1_note;
    logic               p1_live;
    stage_t             p1_stage;
    logic [15:0]        p1_level;
    logic               p1_prev;
    logic [7:0][7:0]    p1_cfg;

    stage_t             stage_edge;
    stage_t             stage_nx;
    logic [1:0]         sel;
    logic [15:0]        target;
    logic [15:0]        step;
    logic [15:0]        level_nx;
    logic [16:0]        sum;
    logic [16:0]        dif;
    logic signed [23:0] wave_ext;
    logic signed [23:0] gain_ext;
    logic signed [23:0] prod;

    assign o_Busy = busy;

    // Init sweep: clear one slot per cycle after reset release, then drop busy
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            busy       <= 1'b1;
            sweep_addr <= 8'd0;
        end else if (busy) begin
            sweep_addr <= sweep_addr + 8'd1;
            if (sweep_addr == LAST_SLOT) begin
                busy <= 1'b0;
            end
        end
    end

    // Host config writes land immediately; a same-cycle read of that slot still sees the old byte
    always_ff @(posedge i_Clock) begin
        if (i_EnvWriteEnable) begin
            cfg_mem[i_EnvWriteAddr][i_EnvWriteParam] <= i_EnvWriteData;
        end
    end

    // Cycle 0: capture the slot ID, sample, note bit and the slot's stored state/config
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            p1_id    <= 8'd0;
            p1_wave  <= 16'sd0;
            p1_note  <= 1'b0;
            p1_live  <= 1'b0;
            p1_stage <= ST_IDLE;
            p1_level <= 16'd0;
            p1_prev  <= 1'b0;
            p1_cfg   <= '0;
        end else begin
            p1_id    <= i_VoiceOperator;
            p1_wave  <= i_Waveform;
            p1_note  <= i_NoteOn[i_VoiceOperator[4:0]];
            p1_live  <= !busy;
            p1_stage <= stage_mem[i_VoiceOperator];
            p1_level <= level_mem[i_VoiceOperator];
            p1_prev  <= prev_mem[i_VoiceOperator];
            p1_cfg   <= cfg_mem[i_VoiceOperator];
        end
    end

    // Cycle 1: note edges pick the stage, then the level moves one clamped step toward the target
    always_comb begin
        stage_edge = p1_stage;
        if (p1_note && !p1_prev) begin
            stage_edge = ST_S1;
        end else if (!p1_note && p1_prev && p1_stage != ST_IDLE) begin
            stage_edge = ST_S4;
        end

        case (stage_edge)
            ST_S2:   sel = 2'd1;
            ST_S3:   sel = 2'd2;
            ST_S4:   sel = 2'd3;
            default: sel = 2'd0;
        endcase

        target   = {p1_cfg[{1'b0, sel}], 8'h00};
        step     = {4'h0, p1_cfg[{1'b1, sel}], 4'h0};
        sum      = {1'b0, p1_level} + {1'b0, step};
        dif      = {1'b0, p1_level} - {1'b0, step};
        level_nx = p1_level;
        stage_nx = stage_edge;

        if (stage_edge != ST_IDLE) begin
            if (p1_level < target) begin
                level_nx = (sum > {1'b0, target}) ? target : sum[15:0];
            end else if (p1_level > target) begin
                level_nx = (dif[16] || dif[15:0] < target) ? target : dif[15:0];
            end
            // S3 is the sustain stage and never advances on its own
            if (level_nx == target) begin
                case (stage_edge)
                    ST_S1:   stage_nx = ST_S2;
                    ST_S2:   stage_nx = ST_S3;
                    ST_S4:   stage_nx = ST_IDLE;
                    default: stage_nx = stage_edge;
                endcase
            end
        end

        wave_ext = {{8{p1_wave[15]}}, p1_wave};
        gain_ext = {16'h0000, level_nx[15:8]};
        prod     = wave_ext * gain_ext;
    end

    // State write-back: the sweep owns the memory while busy, otherwise the cycle-1 slot is stored
    always_ff @(posedge i_Clock) begin
        if (busy) begin
            stage_mem[sweep_addr] <= ST_IDLE;
            level_mem[sweep_addr] <= 16'd0;
            prev_mem[sweep_addr]  <= 1'b0;
        end else if (p1_live) begin
            stage_mem[p1_id] <= stage_nx;
            level_mem[p1_id] <= level_nx;
            prev_mem[p1_id]  <= p1_note;
        end
    end

    // Output registers; slots read during the sweep produce silence
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_VoiceOperator <= 8'd0;
            o_Sample        <= 16'sd0;
            o_EnvelopeLevel <= 8'd0;
        end else begin
            o_VoiceOperator <= p1_id;
            o_Sample        <= p1_live ? 16'(prod >>> 8) : 16'sd0;
            o_EnvelopeLevel <= p1_live ? level_nx[15:8] : 8'd0;
        end
    end

endmodule

// File: tb/tb_stage_envelope.sv
// tb/tb_stage_envelope.sv - scoreboard bench for stage_envelope
module tb_stage_envelope;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         vop = 8'd0;
    logic signed [15:0] wave = 16'sd0;
    logic [31:0]        note_on = 32'd0;
    logic               we = 1'b0;
    logic [2:0]         wp = 3'd0;
    logic [7:0]         wa = 8'd0;
    logic [7:0]         wd = 8'd0;
    logic [7:0]         o_vop;
    logic signed [15:0] o_smp;
    logic [7:0]         o_env;
    logic               o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [7:0]  id;
        logic [15:0] smp;
        logic [7:0]  env;
    } exp_t;

    exp_t sb[$];

    stage_envelope #(.NUM_VOICE_OPS(256)) dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_VoiceOperator (vop),
        .i_Waveform      (wave),
        .i_NoteOn        (note_on),
        .i_EnvWriteEnable(we),
        .i_EnvWriteParam (wp),
        .i_EnvWriteAddr  (wa),
        .i_EnvWriteData  (wd),
        .o_VoiceOperator (o_vop),
        .o_Sample        (o_smp),
        .o_EnvelopeLevel (o_env),
        .o_Busy          (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expected entry must appear exactly on its due cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due != cyc || o_vop !== e.id || o_smp !== e.smp || o_env !== e.env) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d due=%0d vop got %02h want %02h sample got %04h want %04h env got %02h want %02h",
                         cyc, e.due, o_vop, e.id, o_smp, e.smp, o_env, e.env);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step_cycle(input logic [7:0] id, input logic signed [15:0] w, input int exp_level,
                              input logic wr, input logic [2:0] p, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        int   env;
        @(posedge clk);
        #1;
        vop  = id;
        wave = w;
        we   = wr;
        wp   = p;
        wa   = a;
        wd   = d;
        env   = (exp_level >> 8) & 255;
        e.due = cyc + 2;
        e.id  = id;
        e.smp = 16'((int'(w) * env) >>> 8);
        e.env = 8'(env);
        sb.push_back(e);
    endtask

    task automatic filler();
        step_cycle(8'd1, 16'sh1234, 0, 1'b0, 3'd0, 8'd0, 8'd0);
    endtask

    task automatic cfg(input logic [7:0] a, input logic [2:0] p, input logic [7:0] d);
        step_cycle(8'd1, 16'sh1234, 0, 1'b1, p, a, d);
    endtask

    task automatic visit(input logic [7:0] id, input logic signed [15:0] w, input int exp_level);
        step_cycle(id, w, exp_level, 1'b0, 3'd0, 8'd0, 8'd0);
        filler();
    endtask

    task automatic wait_sweep(input string name);
        int c0;
        int fall;
        int bad;
        c0   = cyc;
        fall = -1;
        bad  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_smp != 0 || o_env != 0 || o_vop != 0) bad = 1;
            if (!o_busy) begin
                fall = cyc - c0;
                break;
            end
        end
        check({name, "_busy_cycles"}, fall, 256);
        check({name, "_outputs_zero"}, bad, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int lvl;
        wave = 16'sh7FFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(o_busy), 1);
        check("reset_sample", int'(o_smp), 0);
        check("reset_env", int'(o_env), 0);
        check("reset_vop", int'(o_vop), 0);

        // Reset in the middle of a sweep must restart it from slot 0
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midsweep_reset_busy", int'(o_busy), 1);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_sweep("sweep");

        cfg(8'd0, 3'd0, 8'h80); cfg(8'd0, 3'd1, 8'h60); cfg(8'd0, 3'd2, 8'h60); cfg(8'd0, 3'd3, 8'h00);
        cfg(8'd0, 3'd4, 8'h10); cfg(8'd0, 3'd5, 8'h20); cfg(8'd0, 3'd6, 8'h01); cfg(8'd0, 3'd7, 8'hFF);
        cfg(8'd2, 3'd0, 8'hFF); cfg(8'd2, 3'd4, 8'hFF);
        cfg(8'd5, 3'd0, 8'hFF); cfg(8'd5, 3'd4, 8'h10);

        // Attack at +0x100 per visit to 0x8000, decay at -0x200 to 0x6000, sustain
        note_on[0] = 1'b1;
        for (int n = 1; n <= 128; n++) visit(8'd0, 16'sh4000, n * 256);
        for (int n = 1; n <= 16; n++) visit(8'd0, 16'sh4000, 32768 - 512 * n);
        for (int n = 1; n <= 4; n++) visit(8'd0, 16'sh4000, 24576);

        // Release at -0x0FF0 per visit, clamp at 0, then idle ignores a new L4
        note_on[0] = 1'b0;
        for (int m = 1; m <= 8; m++) begin
            lvl = 24576 - 4080 * m;
            if (lvl < 0) lvl = 0;
            visit(8'd0, 16'sh4000, lvl);
        end
        cfg(8'd0, 3'd3, 8'h10);
        visit(8'd0, 16'sh4000, 0);
        visit(8'd0, 16'sh4000, 0);

        // Retrigger while releasing at 0x3000 keeps the level
        cfg(8'd0, 3'd3, 8'h00); cfg(8'd0, 3'd7, 8'hC0); cfg(8'd0, 3'd4, 8'hFF);
        note_on[0] = 1'b1;
        for (int n = 1; n <= 8; n++) visit(8'd0, 16'sh4000, 4080 * n);
        visit(8'd0, 16'sh4000, 32768);
        for (int n = 1; n <= 16; n++) visit(8'd0, 16'sh4000, 32768 - 512 * n);
        visit(8'd0, 16'sh4000, 24576);
        visit(8'd0, 16'sh4000, 24576);
        note_on[0] = 1'b0;
        for (int m = 1; m <= 4; m++) visit(8'd0, 16'sh4000, 24576 - 3072 * m);
        note_on[0] = 1'b1;
        visit(8'd0, 16'sh4000, 16'h3FF0);
        visit(8'd0, 16'sh4000, 16'h4FE0);

        // Same-cycle config write: old rate this visit, new rate afterwards
        note_on[5] = 1'b1;
        visit(8'd5, 16'sh4000, 16'h0100);
        step_cycle(8'd5, 16'sh4000, 16'h0200, 1'b1, 3'd4, 8'd5, 8'h30);
        filler();
        visit(8'd5, 16'sh4000, 16'h0500);
        visit(8'd5, 16'sh4000, 16'h0800);

        // Full-scale negative waveform and truncation toward minus infinity
        note_on[2] = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            if (n == 15) visit(8'd2, 16'shFFFF, 4080 * n);
            else         visit(8'd2, 16'sh8000, 4080 * n);
        end

        // Reset mid-operation clears state but keeps config
        drain();
        vop  = 8'd0;
        wave = 16'sh7FFF;
        note_on = 32'd0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("op_reset_busy", int'(o_busy), 1);
        check("op_reset_sample", int'(o_smp), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_sweep("resweep");
        filler();
        note_on[0] = 1'b1;
        visit(8'd0, 16'sh4000, 16'h0FF0);
        visit(8'd0, 16'sh4000, 16'h1FE0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_envelope.md
STAGE_ENVELOPE -- requirements
Module: stage_envelope

Interface
REQ-001 SHALL have parameter NUM_VOICE_OPS, default 256, meaning number of voice-operator slots (8 operators x 32 voices).
REQ-002 SHALL have port i_Clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_Reset_n, input, 1, meaning reset; it is asynchronous and active-low.
REQ-004 SHALL have port i_VoiceOperator, input, 8, meaning the current slot ID; bits [7:5] are the operator and bits [4:0] are the voice.
REQ-005 SHALL have port i_Waveform, input, 16 signed, meaning the waveform sample for i_VoiceOperator, valid in the same cycle.
REQ-006 SHALL have port i_NoteOn, input, 32, meaning per-voice note-on level, bit n for voice n.
REQ-007 SHALL have port i_EnvWriteEnable, input, 1, meaning the envelope config write strobe.
REQ-008 SHALL have port i_EnvWriteParam, input, 3, meaning the config field: 0-3 are L1-L4 and 4-7 are R1-R4.
REQ-009 SHALL have port i_EnvWriteAddr, input, 8, meaning the target slot ID.
REQ-010 SHALL have port i_EnvWriteData, input, 8, meaning the config value.
REQ-011 SHALL have port o_VoiceOperator, output, 8, meaning i_VoiceOperator delayed 2 cycles.
REQ-012 SHALL have port o_Sample, output, 16 signed, meaning the enveloped sample for o_VoiceOperator.
REQ-013 SHALL have port o_EnvelopeLevel, output, 8, meaning the gain applied to o_Sample, which is level[15:8].
REQ-014 SHALL have port o_Busy, output, 1, meaning the state-memory init sweep is in progress.

Function
REQ-015 SHALL hold per-slot state: stage (IDLE, S1, S2, S3, S4), 16-bit unsigned level, and prevNoteOn; and per-slot config L1-L4 and R1-R4.
REQ-016 SHALL pipeline each slot in two cycles: cycle 0 reads state/config and registers i_Waveform and ID; cycle 1 computes, writes back state, and registers the outputs.
REQ-017 SHALL have a fixed latency of 2 cycles from i_VoiceOperator and i_Waveform to o_VoiceOperator, o_Sample and o_EnvelopeLevel, with no stalls.
REQ-018 SHALL use, in the active stage Sk (k=1..4), target T = {Lk,8'h00} and step = {4'h0,Rk,4'h0}.
REQ-019 SHALL move the level toward T by one step each visit: if level<T, level=min(level+step,T); if level>T, level=max(level-step,T); arithmetic is 17-bit with no wrap.
REQ-020 SHALL, on a visit where the new level equals T, advance S1 to S2, S2 to S3, and S4 to IDLE; S3 holds at L3 while the note is on.
REQ-021 SHALL hold the stage forever when Rk=0 and level!=T; this is legal.
REQ-022 SHALL leave the level unchanged in IDLE.
REQ-023 SHALL, on note-on rising (i_NoteOn[voice]=1, prevNoteOn=0), enter S1 from any stage, keep the current level, and apply S1 movement on that same visit.
REQ-024 SHALL, on note-on falling, enter S4 from S1, S2 or S3 and apply S4 movement on that visit; a falling edge while in IDLE has no effect.
REQ-025 SHALL update prevNoteOn every visit; note edges are sampled only at the owning slot's visit.
REQ-026 SHALL compute o_Sample = (i_Waveform x level[15:8]) >>> 8, a signed 16 x unsigned 8 product to 24 bits, taking bits [23:8]; truncation is toward minus infinity.
REQ-027 SHALL apply a config write in the cycle it is strobed; a slot read in that same cycle sees the old value and the new value is used from the next visit.
REQ-028 SHALL not guard against read-after-write hazards on state, because a slot recurs every 256 cycles.

Reset
REQ-029 SHALL, while i_Reset_n=0, force o_VoiceOperator=0, o_Sample=0, o_EnvelopeLevel=0, o_Busy=1, and clear the pipeline registers.
REQ-030 SHALL, after reset release, sweep state for slots 0..255, one per cycle, to IDLE with level=0 and prevNoteOn=0.
REQ-031 SHALL drive o_Busy low in the cycle after slot 255 is written, and SHALL hold o_Sample=0 and o_EnvelopeLevel=0 while o_Busy=1.
REQ-032 SHALL NOT clear config on reset; configuration is owned by the host.
REQ-033 SHALL, on reset asserted mid-sweep or mid-operation, restart the sweep from slot 0 after release.

Verification
REQ-034 SHALL be covered by: reset, then 256 cycles -> o_Busy falls on cycle 257; all outputs are 0 throughout.
REQ-035 SHALL be covered by: slot 0 with L1=0x80, R1=0x10 and voice 0 note on; i_Waveform=0x4000 -> level +0x100 per visit; EnvelopeLevel=0x80 at visit 128; stage S2 next; o_Sample=0x2000 at visit 128.
REQ-036 SHALL be covered by: S3 with L3=0x60 held, then note off with L4=0x00, R4=0xFF -> level falls 0x0FF0 per visit, clamps at 0, and ends IDLE.
REQ-037 SHALL be covered by: note retrigger during S4 at level 0x3000 -> S1 from 0x3000 with no reset to 0.
REQ-038 SHALL be covered by: i_Waveform=0x8000 with level[15:8]=0xFF -> o_Sample=0x8080; check the latency of 2 and the o_VoiceOperator match.
REQ-039 SHALL be covered by: a config write to slot 5 R1 in the same cycle slot 5 is read -> the old rate is used this visit and the new rate next visit.
